// File: rtl/sub4bit_serial.sv
// sub4bit_serial: bit-serial subtractor computing D = A - B - Bin, LSB first,
// one bit per clock. IDLE accepts a request, RUN takes WIDTH cycles, and DONE
// marks the result with a one-cycle done pulse.
module sub4bit_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic             br;
  logic             br_nxt;
  logic             dbit;
  logic [CW-1:0]    cnt;

  // Next-state decode and datapath control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One full-subtractor bit slice on the current LSBs
  always_comb begin
    dbit   = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    r_nxt  = (r_sr >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
  end

  // State register; busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand/result shift registers, borrow flop, bit counter, result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bo   <= 1'b0;
    end else if (load) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (step) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_nxt;
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      if (last) begin
        D  <= r_nxt;
        Bo <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sub4bit_serial.sv
// Self-checking bench for sub4bit_serial: directed vectors, start-while-busy,
// reset mid-operation, back-to-back starts, exhaustive sweep and random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_sub4bit_serial;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;

  // reference model: cycles left in the current operation (0 = idle)
  int           m_cnt = 0;
  logic [W-1:0] m_d = '0;
  logic         m_bo = 1'b0;
  logic [W:0]   m_pend = '0;
  logic         m_acc = 1'b0;

  sub4bit_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Bin(bin),
    .busy(busy), .done(done), .D(d), .Bo(bo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // advance one clock, step the model with the sampled inputs, compare outputs
  task automatic tick();
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      m_cnt = 0;
      m_d   = '0;
      m_bo  = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  = W + 1;
        m_pend = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        m_acc  = 1'b1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) {m_bo, m_d} = m_pend;
    end
    #1;
    cyc++;
    if (done === 1'b1) n_done++;
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("done", 32'(done), 32'(m_cnt == 1));
    chk("D",    32'(d),    32'(m_d));
    chk("Bo",   32'(bo),   32'(m_bo));
  endtask

  // run ticks with junk inputs (and ignored starts) until idle, bounded
  task automatic drain();
    int i;
    for (i = 0; i < 20 && (m_cnt != 0 || busy !== 1'b0); i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      start = 1'($urandom);
      tick();
    end
    start = 1'b0;
    if (i >= 20) chk("drain_timeout", 32'(1), 32'(0));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic [W-1:0] ed, input logic ebo,
                        input string tag);
    int nd0;
    nd0   = n_done;
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();
    chk({tag, "_ndone"}, 32'(n_done - nd0), 32'(1));
    chk({tag, "_D"},     32'(d),  32'(ed));
    chk({tag, "_Bo"},    32'(bo), 32'(ebo));
  endtask

  logic [W-1:0] va [3];
  logic [W-1:0] vb [3];
  logic         vc [3];
  logic [W-1:0] vd [3];
  logic         ve [3];

  initial begin
    int nd0;
    int idx;
    int ndn;
    int last_dc;
    int diff;

    // reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_D",    32'(d),    32'(0));
    rst = 1'b0;

    // idle holds with start low
    tick();
    tick();

    // directed vectors
    run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, "v1");
    run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, "v2");
    run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "v3");
    run_op(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, "v4");
    run_op(4'b1000, 4'b0001, 1'b1, 4'b0110, 1'b0, "v5");

    // start ignored while busy
    nd0 = n_done;
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'b1111; b = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    drain();
    tick();
    chk("ign_ndone", 32'(n_done - nd0), 32'(1));
    chk("ign_D",     32'(d),    32'(4'b0010));
    chk("ign_busy",  32'(busy), 32'(0));

    // reset in the 2nd RUN cycle
    nd0 = n_done;
    a = 4'b1111; b = 4'b0001; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_D",    32'(d),    32'(0));
    chk("mrst_Bo",   32'(bo),   32'(0));
    rst = 1'b0;
    run_op(4'b0010, 4'b0001, 1'b0, 4'b0001, 1'b0, "post_rst");
    chk("mrst_ndone", 32'(n_done - nd0), 32'(1));

    // back-to-back with start held high
    va[0] = 4'b0101; vb[0] = 4'b0011; vc[0] = 1'b0; vd[0] = 4'b0010; ve[0] = 1'b0;
    va[1] = 4'b0000; vb[1] = 4'b0000; vc[1] = 1'b1; vd[1] = 4'b1111; ve[1] = 1'b1;
    va[2] = 4'b1111; vb[2] = 4'b1111; vc[2] = 1'b0; vd[2] = 4'b0000; ve[2] = 1'b0;
    idx = 0; ndn = 0; last_dc = 0;
    a = va[0]; b = vb[0]; bin = vc[0]; start = 1'b1;
    for (int i = 0; i < 40 && !(idx == 3 && m_cnt == 0); i++) begin
      tick();
      if (m_acc) begin
        idx++;
        if (idx < 3) begin
          a = va[idx]; b = vb[idx]; bin = vc[idx];
        end else begin
          start = 1'b0;
        end
      end
      if (done === 1'b1 && ndn < 3) begin
        chk("b2b_D",  32'(d),  32'(vd[ndn]));
        chk("b2b_Bo", 32'(bo), 32'(ve[ndn]));
        if (ndn > 0) chk("b2b_gap", 32'(cyc - last_dc), 32'(W + 2));
        last_dc = cyc;
        ndn++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(ndn), 32'(3));

    // exhaustive sweep, expected value from signed integer arithmetic
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          diff = ia - ib - ic;
          repeat ($urandom_range(0, 2)) tick();
          run_op(W'(ia), W'(ib), 1'(ic), W'(diff & 15), 1'(diff < 0), "exh");
        end
      end
    end

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub4bit_serial.md
SUB4BIT_SERIAL -- requirements
Module: sub4bit_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits; all other requirements and vectors use WIDTH=4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction.
REQ-005 SHALL have port A  input  WIDTH  minuend, sampled only on accepted start.
REQ-006 SHALL have port B  input  WIDTH  subtrahend, sampled only on accepted start.
REQ-007 SHALL have port Bin  input  1  borrow-in, sampled only on accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 SHALL have port done  output  1  single-cycle pulse marking D/Bo valid.
REQ-010 SHALL have port D  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH.
REQ-011 SHALL have port Bo  output  1  borrow-out: 1 iff A < B + Bin (unsigned).

Function
REQ-012 SHALL implement an FSM with exactly three states: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start=1 at an edge, latch A, B and Bin into internal shift registers and the borrow flip-flop, clear the bit counter to 0, and enter RUN.
REQ-014 SHALL, in IDLE with start=0, remain in IDLE with D and Bo unchanged.
REQ-015 SHALL process one bit per RUN cycle, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 SHALL shift operand registers right by one each RUN cycle and shift d into the MSB of the result register.
REQ-017 SHALL increment the bit counter each RUN cycle and leave RUN for DONE on the edge that processes bit WIDTH-1 (exactly WIDTH RUN cycles).
REQ-018 SHALL, on the RUN->DONE edge, update D with the full result register and Bo with the final borrow.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-020 SHALL give latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH (k+4), D/Bo valid from that same cycle.
REQ-021 SHALL hold D and Bo stable from DONE until the edge that next enters DONE, so they are not disturbed while a new operation runs.
REQ-022 SHALL ignore start while in RUN or DONE; no operand re-sampling, no restart, no counter change.
REQ-023 SHALL accept back-to-back operations: start held high continuously yields one operation per WIDTH+2 cycles.
REQ-024 SHALL drive busy = 1 in RUN and DONE, 0 in IDLE; busy is a registered/state-decoded output with no combinational path from start.
REQ-025 SHALL produce D and Bo identical to (A - B - Bin) computed in WIDTH+1 bit unsigned arithmetic, with Bo = bit WIDTH of that result.

Reset
REQ-026 SHALL, when rst=1 at an edge, enter IDLE and clear D=0, Bo=0, done=0, busy=0, counter=0, borrow flip-flop=0, and shift registers=0.
REQ-027 SHALL give rst priority over start and over any in-flight operation; an operation interrupted by rst produces no done pulse and leaves D/Bo at 0.
REQ-028 SHALL accept a new start on the first edge after rst deasserts.

Verification
REQ-029 SHALL be checked with A=0101, B=0011, Bin=0 -> done 5 cycles after start edge, D=0010, Bo=0; A=0011, B=0101, Bin=0 -> D=1110, Bo=1.
REQ-030 SHALL be checked at boundaries: A=0000, B=0000, Bin=1 -> D=1111, Bo=1; A=1111, B=1111, Bin=0 -> D=0000, Bo=0; A=1000, B=0001, Bin=1 -> D=0110, Bo=0.
REQ-031 SHALL be checked for start ignored while busy: start A=0101, B=0011, then pulse start with A=1111, B=0000 two cycles later -> single done pulse, D=0010, busy low exactly one cycle after done.
REQ-032 SHALL be checked for reset mid-operation: start A=1111, B=0001, assert rst on the 2nd RUN cycle -> busy=0, done never pulses, D=0000, Bo=0; a subsequent start A=0010, B=0001 -> D=0001, Bo=0.
REQ-033 SHALL be checked with start held high for 3 consecutive operations (vectors of REQ-029/030) -> done pulses spaced exactly 6 cycles, each D/Bo matching its vector and stable until the next done.
REQ-034 SHALL be checked exhaustively (all 512 A/B/Bin combinations) against REQ-025 with a self-checking compare on every done pulse.
